// File: rtl/vc_reader_if.sv
// Bundle of the two VC FIFO pop ports, the downstream push port and the status
// outputs of the VC reader. The reader uses the master side; FIFOs/bench use slave.
interface vc_reader_if #(
  parameter int BW16 = 16,
  parameter int CNTW = 8
);
  logic            VC0_empty;
  logic [BW16-1:0] VC0_data_in;
  logic            VC0_rd;
  logic            VC1_empty;
  logic [BW16-1:0] VC1_data_in;
  logic            VC1_rd;
  logic            D_almost_full;
  logic            D_full;
  logic            D_wr;
  logic [BW16-1:0] D_data_out;
  logic [CNTW-1:0] cnt_vc0;
  logic [CNTW-1:0] cnt_vc1;
  logic            error_output;

  modport master (
    input  VC0_empty, VC0_data_in, VC1_empty, VC1_data_in, D_almost_full, D_full,
    output VC0_rd, VC1_rd, D_wr, D_data_out, cnt_vc0, cnt_vc1, error_output
  );

  modport slave (
    output VC0_empty, VC0_data_in, VC1_empty, VC1_data_in, D_almost_full, D_full,
    input  VC0_rd, VC1_rd, D_wr, D_data_out, cnt_vc0, cnt_vc1, error_output
  );
endinterface

// File: rtl/vc_reader.sv
// Drains two VC FIFOs into one downstream FIFO: VC0 has priority, VC1 gets a slot
// after every W0 consecutive VC0 grants. Two-cycle pop-to-push pipeline.
module vc_reader #(
  parameter int BW16 = 16,
  parameter int W0   = 4,
  parameter int CNTW = 8
) (
  input  logic       clk,
  input  logic       reset,
  vc_reader_if.master bus
);

  localparam logic [3:0] W0_L = 4'(W0);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= W0_L) ? W0_L : v + 4'd1;
  endfunction

  logic            issue;
  logic            pop0;
  logic            pop1;
  logic [3:0]      burst_cnt;
  logic            vld_p0;
  logic            sel_p0;
  logic            vld_p1;
  logic            sel_p1;
  logic [BW16-1:0] data_p1;
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;
  logic            err;

  always_comb begin
    issue = !reset && !bus.D_almost_full && !bus.D_full;
    pop0  = 1'b0;
    pop1  = 1'b0;
    if (issue) begin
      if (!bus.VC0_empty && !bus.VC1_empty) begin
        if (burst_cnt < W0_L) pop0 = 1'b1;
        else                  pop1 = 1'b1;
      end else if (!bus.VC0_empty) begin
        pop0 = 1'b1;
      end else if (!bus.VC1_empty) begin
        pop1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 4'd0;
      vld_p0    <= 1'b0;
      sel_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      sel_p1    <= 1'b0;
      data_p1   <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
      err       <= 1'b0;
    end else begin
      if (pop0)      burst_cnt <= sat_inc(burst_cnt);
      else if (pop1) burst_cnt <= 4'd0;

      // p0: pop issued this edge, remember which FIFO will present data next cycle
      vld_p0 <= pop0 || pop1;
      sel_p0 <= pop1;

      // p1: FIFO data valid now, capture into the downstream write register
      vld_p1 <= vld_p0;
      sel_p1 <= sel_p0;
      if (vld_p0) data_p1 <= sel_p0 ? bus.VC1_data_in : bus.VC0_data_in;

      // push retires: account the word and flag a push into a full FIFO
      if (vld_p1) begin
        if (sel_p1) cnt1 <= cnt1 + CNTW'(1);
        else        cnt0 <= cnt0 + CNTW'(1);
        if (bus.D_full) err <= 1'b1;
      end
    end
  end

  assign bus.VC0_rd       = pop0;
  assign bus.VC1_rd       = pop1;
  assign bus.D_wr         = vld_p1;
  assign bus.D_data_out   = data_p1;
  assign bus.cnt_vc0      = cnt0;
  assign bus.cnt_vc1      = cnt1;
  assign bus.error_output = err;

endmodule

// File: tb/tb_vc_reader.sv
// Directed bench for vc_reader: behavioural VC FIFOs with one-cycle read latency,
// a push/pop monitor, and hand-computed expected grant orders, data and counters.
module tb_vc_reader;
  localparam int BW16 = 16;
  localparam int W0   = 4;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_reader_if #(.BW16(BW16), .CNTW(CNTW)) bus ();
  vc_reader #(.BW16(BW16), .W0(W0), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          pop_vc[$];
  int          pop_cyc[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          pop0_n = 0;
  int          pop1_n = 0;
  int          wr_n   = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO models sample pops mid-cycle and update just after the edge
  initial begin : fifo_model
    logic r0, r1;
    bus.VC0_empty = 1'b1;
    bus.VC1_empty = 1'b1;
    bus.VC0_data_in = '0;
    bus.VC1_data_in = '0;
    forever begin
      @(negedge clk);
      r0 = bus.VC0_rd;
      r1 = bus.VC1_rd;
      if (r0) begin pop_vc.push_back(0); pop_cyc.push_back(cyc); pop0_n++; end
      if (r1) begin pop_vc.push_back(1); pop_cyc.push_back(cyc); pop1_n++; end
      if (bus.D_wr) begin wr_data.push_back(bus.D_data_out); wr_cyc.push_back(cyc); wr_n++; end
      @(posedge clk);
      #1;
      if (r0 && q0.size() > 0) bus.VC0_data_in = q0.pop_front();
      if (r1 && q1.size() > 0) bus.VC1_data_in = q1.pop_front();
      bus.VC0_empty = (q0.size() == 0);
      bus.VC1_empty = (q1.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    pop_vc.delete(); pop_cyc.delete(); wr_data.delete(); wr_cyc.delete();
    pop0_n = 0; pop1_n = 0; wr_n = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.D_almost_full = 1'b0;
    bus.D_full = 1'b0;
    q0.delete(); q1.delete();
    bus.VC0_empty = 1'b1;
    bus.VC1_empty = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    clear_logs();
  endtask

  task automatic load0(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) q0.push_back(base + 16'(i));
    bus.VC0_empty = 1'b0;
  endtask

  task automatic load1(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) q1.push_back(base + 16'(i));
    bus.VC1_empty = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (wr_n < n && k < budget) begin tick(1); k++; end
    check_eq(tag, 32'(wr_n >= n), 32'd1);
  endtask

  int order2 [20] = '{0,0,0,0,1,0,0,0,0,1,0,0,1,1,1,1,1,1,1,1};

  initial begin : main
    int i0, i1, k, before_wr, before_pop;
    logic [15:0] exp_d;
    reset = 1'b1;
    bus.D_almost_full = 1'b0;
    bus.D_full = 1'b0;
    tick(2);

    // reset state, pops held off while reset is high
    load0(16'h0100, 1);
    load1(16'h0200, 1);
    #1;
    check_eq("rst_vc0_rd", 32'(bus.VC0_rd), 0);
    check_eq("rst_vc1_rd", 32'(bus.VC1_rd), 0);
    check_eq("rst_d_wr", 32'(bus.D_wr), 0);
    check_eq("rst_d_data", 32'(bus.D_data_out), 0);
    check_eq("rst_cnt0", 32'(bus.cnt_vc0), 0);
    check_eq("rst_cnt1", 32'(bus.cnt_vc1), 0);
    check_eq("rst_err", 32'(bus.error_output), 0);
    do_reset();

    // reset mid-burst
    load0(16'h0E00, 6);
    k = 0;
    while (pop0_n < 3 && k < 20) begin tick(1); k++; end
    check_eq("mid_pre_wr", 32'(bus.D_wr), 1);
    check_eq("mid_pre_cnt0", 32'(bus.cnt_vc0), 1);
    reset = 1'b1;
    #1;
    check_eq("mid_d_wr", 32'(bus.D_wr), 0);
    check_eq("mid_cnt0", 32'(bus.cnt_vc0), 0);
    check_eq("mid_d_data", 32'(bus.D_data_out), 0);
    q0.delete();
    bus.VC0_empty = 1'b1;
    tick(2);
    reset = 1'b0;
    before_wr = wr_n;
    tick(5);
    check_eq("mid_no_wr_after", 32'(wr_n - before_wr), 0);
    do_reset();

    // weighted arbitration, W0=4, 10 words each
    load0(16'h0A00, 10);
    load1(16'h0B00, 10);
    wait_writes(20, 100, "arb_done");
    tick(3);
    i0 = 0; i1 = 0;
    for (int j = 0; j < 20; j++) begin
      if (order2[j] == 1) begin exp_d = 16'h0B00 + 16'(i1); i1++; end
      else                begin exp_d = 16'h0A00 + 16'(i0); i0++; end
      check_eq($sformatf("arb_vc%0d", j), (j < pop_vc.size()) ? 32'(pop_vc[j]) : 32'hDEAD, 32'(order2[j]));
      check_eq($sformatf("arb_data%0d", j), (j < wr_data.size()) ? 32'(wr_data[j]) : 32'hDEAD, 32'(exp_d));
      check_eq($sformatf("arb_lat%0d", j),
               (j < wr_cyc.size() && j < pop_cyc.size()) ? 32'(wr_cyc[j] - pop_cyc[j]) : 32'hDEAD, 32'd2);
    end
    check_eq("arb_wr_n", 32'(wr_n), 20);
    check_eq("arb_cnt0", 32'(bus.cnt_vc0), 10);
    check_eq("arb_cnt1", 32'(bus.cnt_vc1), 10);
    do_reset();

    // VC1 only
    load1(16'h0001, 5);
    wait_writes(5, 50, "vc1_done");
    tick(3);
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("vc1_data%0d", j), (j < wr_data.size()) ? 32'(wr_data[j]) : 32'hDEAD, 32'(j + 1));
      check_eq($sformatf("vc1_cyc%0d", j),
               (j < wr_cyc.size() && pop_cyc.size() > 0) ? 32'(wr_cyc[j] - pop_cyc[0]) : 32'hDEAD, 32'(j + 2));
    end
    check_eq("vc1_pops1", 32'(pop1_n), 5);
    check_eq("vc1_pops0", 32'(pop0_n), 0);
    check_eq("vc1_cnt1", 32'(bus.cnt_vc1), 5);
    check_eq("vc1_cnt0", 32'(bus.cnt_vc0), 0);
    do_reset();

    // backpressure after the third VC0 pop
    load0(16'h0C00, 8);
    k = 0;
    while (pop0_n < 3 && k < 20) begin tick(1); k++; end
    bus.D_almost_full = 1'b1;
    before_wr = wr_n;
    before_pop = pop0_n;
    tick(6);
    check_eq("bp_no_pops", 32'(pop0_n - before_pop), 0);
    check_eq("bp_trailing_wr", 32'(wr_n - before_wr), 2);
    bus.D_almost_full = 1'b0;
    tick(1);
    check_eq("bp_resume", 32'(pop0_n), 4);
    wait_writes(8, 50, "bp_done");
    tick(4);
    check_eq("bp_wr_n", 32'(wr_n), 8);
    for (int j = 0; j < 8; j++)
      check_eq($sformatf("bp_data%0d", j), (j < wr_data.size()) ? 32'(wr_data[j]) : 32'hDEAD, 32'(16'h0C00 + 16'(j)));
    check_eq("bp_cnt0", 32'(bus.cnt_vc0), 8);
    do_reset();

    // push into a full downstream FIFO
    load0(16'h0D00, 1);
    k = 0;
    while (bus.D_wr !== 1'b1 && k < 20) begin tick(1); k++; end
    check_eq("err_saw_wr", 32'(bus.D_wr), 1);
    bus.D_full = 1'b1;
    check_eq("err_before", 32'(bus.error_output), 0);
    tick(1);
    check_eq("err_set", 32'(bus.error_output), 1);
    bus.D_full = 1'b0;
    tick(20);
    check_eq("err_sticky", 32'(bus.error_output), 1);
    do_reset();
    check_eq("err_cleared", 32'(bus.error_output), 0);

    // counter wrap
    load0(16'h1000, 260);
    wait_writes(260, 400, "wrap_done");
    tick(3);
    check_eq("wrap_cnt0", 32'(bus.cnt_vc0), 4);
    check_eq("wrap_cnt1", 32'(bus.cnt_vc1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vc_reader.md
Name: vc_reader

Overview:
- Pop-side companion of the per-virtual-channel FIFOs (VC0, VC1).
- Drains both VC FIFOs under a weighted-priority QoS policy and writes the merged stream into one downstream FIFO.
- VC0 has high priority. VC1 is guaranteed one slot after every W0 consecutive VC0 grants.
- Honours downstream backpressure, keeps per-VC forwarded-word counters and flags overflow errors.

Parameters:
- BW16, 16: data width of every VC and downstream word.
- W0, 4: maximum consecutive VC0 grants while VC1 is non-empty (1..15).
- CNTW, 8: width of the per-VC forwarded-word counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- VC0_empty  input  1  VC0 FIFO empty flag.
- VC0_data_in  input  BW16  VC0 FIFO data out; valid the cycle after VC0_rd.
- VC0_rd  output  1  VC0 FIFO pop.
- VC1_empty  input  1  VC1 FIFO empty flag.
- VC1_data_in  input  BW16  VC1 FIFO data out; valid the cycle after VC1_rd.
- VC1_rd  output  1  VC1 FIFO pop.
- D_almost_full  input  1  downstream FIFO almost-full; stops new pops.
- D_full  input  1  downstream FIFO full.
- D_wr  output  1  downstream FIFO push.
- D_data_out  output  BW16  downstream write data.
- cnt_vc0  output  CNTW  words forwarded from VC0.
- cnt_vc1  output  CNTW  words forwarded from VC1.
- error_output  output  1  sticky overflow error.

Behaviour:
- Reset (asynchronous, any time): D_wr=0, D_data_out=0, cnt_vc0=0, cnt_vc1=0, error_output=0, burst_cnt=0, pipeline valid bits cleared.
  - Words in flight when reset asserts are dropped.
  - VC0_rd and VC1_rd are 0 while reset is high.
- Issue enable: issue = !reset & !D_almost_full & !D_full.
- Arbitration (combinational, from registered burst_cnt and the empty flags); at most one pop per cycle:
  - Both non-empty: VC0_rd=1 if burst_cnt < W0, else VC1_rd=1.
  - Only VC0 non-empty: VC0_rd=1.
  - Only VC1 non-empty: VC1_rd=1.
  - Neither non-empty, or issue=0: no pop.
- burst_cnt (4-bit state register):
  - VC0 grant: increment, saturating at W0.
  - VC1 grant: clear to 0.
  - No grant: hold.
  - If VC1 becomes non-empty while burst_cnt=W0, VC1 wins the next grant.
- Empty flags reflect occupancy after the previous edge. Back-to-back pops from the same FIFO are legal whenever its empty flag is 0.
- Pipeline, total latency 2 cycles:
  - Cycle N: pop. Register sel_q (which VC) and v1=1.
  - Cycle N+1: FIFO data valid. Capture the selected VCx_data_in into D_data_out and set D_wr=1 from v1 (registered outputs).
  - Cycle N+2: D_wr=1 with D_data_out stable.
  - D_data_out holds its last value when D_wr=0.
- Backpressure:
  - When D_almost_full rises, words already popped still complete; up to 2 words are in flight.
  - The downstream almost-full threshold leaves at least 2 free entries.
  - The reader never stalls the pipeline.
- Counters: cnt_vc0/cnt_vc1 increment on the edge where D_wr is asserted for a word from that VC, and wrap modulo 2^CNTW.
- Error: at any edge where D_wr=1 and D_full=1, error_output is set and stays 1 until reset. The word is still presented; no retry.
- Order: words from one VC leave in pop order. Interleaving follows grant order exactly.

Test Plan:
- Reset mid-burst: assert reset with 2 words in flight -> D_wr=0 and counters 0 immediately; no D_wr after release until new pops.
- W0=4, VC0 and VC1 each preloaded with 10 words, D_almost_full=0 -> grant order 0,0,0,0,1,0,0,0,0,1,0,0,1,1,1,1,1,1,1,1.
  - Each D_wr occurs 2 cycles after its pop.
  - Final cnt_vc0=10, cnt_vc1=10.
- Only VC1 loaded with 0x0001..0x0005 -> 5 consecutive VC1_rd; D_data_out=0x0001..0x0005 on consecutive cycles starting 2 cycles after the first pop.
- D_almost_full raised after the 3rd VC0 pop (8 words queued) -> no pops while high; exactly 2 trailing D_wr; resumes the cycle after it falls; no word lost or duplicated.
- Force D_full=1 during a D_wr -> error_output=1 next edge and held through 20 idle cycles until reset.
- CNTW=8, 260 VC0 words forwarded -> cnt_vc0=4 (wrap), cnt_vc1=0.
